// File: rtl/sorted_insert_if.sv
// Request/status and external-RAM signals for the sorted_insert engine.
// The engine attaches through the slave modport; the requester and RAM sit on the master side.
interface sorted_insert_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  s;
  logic                  clr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_wren;
  logic [ADDR_WIDTH:0]   count;
  logic                  busy;
  logic                  done;
  logic                  full;

  modport slave (
    input  s, clr, data_in, ram_rdata,
    output ram_addr, ram_wdata, ram_wren, count, busy, done, full
  );

  modport master (
    output s, clr, data_in, ram_rdata,
    input  ram_addr, ram_wdata, ram_wren, count, busy, done, full
  );
endinterface

// File: rtl/sorted_insert.sv
// One insertion-sort step into an external synchronous-read RAM: scan down from the top,
// shift larger entries up one slot, then drop the new value into the gap.
module sorted_insert #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic            clk,
  input  logic            reset,
  sorted_insert_if.slave  bus
);
  localparam int                  N       = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_N   = (ADDR_WIDTH + 1)'(N);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {IDLE, READ, CMP, WRITE, DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_a, w_a_nxt;
  logic [ADDR_WIDTH:0]   r_i, w_i_nxt;
  logic [ADDR_WIDTH:0]   r_count, w_count_nxt;
  logic                  r_rej, w_rej_nxt;

  logic [ADDR_WIDTH:0]   w_i_m1;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_wren;

  assign w_i_m1 = r_i - CNT_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_i     <= '0;
      r_count <= '0;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_i     <= w_i_nxt;
      r_count <= w_count_nxt;
      r_rej   <= w_rej_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_i_nxt     = r_i;
    w_count_nxt = r_count;
    w_rej_nxt   = r_rej;
    w_addr      = '0;
    w_wdata     = r_a;
    w_wren      = 1'b0;

    case (r_state)
      IDLE: begin
        w_a_nxt = bus.data_in;
        if (bus.clr && !bus.s) begin
          w_count_nxt = '0;
        end
        if (bus.s) begin
          if (r_count == CNT_N) begin
            w_rej_nxt   = 1'b1;
            w_state_nxt = DONE;
          end else if (r_count == '0) begin
            w_i_nxt     = '0;
            w_state_nxt = WRITE;
          end else begin
            w_i_nxt     = r_count;
            w_rej_nxt   = 1'b0;
            w_state_nxt = READ;
          end
        end
      end

      READ: begin
        w_addr      = w_i_m1[ADDR_WIDTH-1:0];
        w_state_nxt = CMP;
      end

      // Strict greater-than: an equal entry stops the scan, keeping duplicates in arrival order.
      CMP: begin
        if (bus.ram_rdata > r_a) begin
          w_addr      = r_i[ADDR_WIDTH-1:0];
          w_wdata     = bus.ram_rdata;
          w_wren      = 1'b1;
          w_i_nxt     = w_i_m1;
          w_state_nxt = (w_i_m1 == '0) ? WRITE : READ;
        end else begin
          w_state_nxt = WRITE;
        end
      end

      WRITE: begin
        w_addr      = r_i[ADDR_WIDTH-1:0];
        w_wdata     = r_a;
        w_wren      = 1'b1;
        w_count_nxt = r_count + CNT_ONE;
        w_rej_nxt   = 1'b0;
        w_state_nxt = DONE;
      end

      DONE: begin
        if (!bus.s) begin
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.ram_addr  = w_addr;
  assign bus.ram_wdata = w_wdata;
  assign bus.ram_wren  = w_wren;
  assign bus.count     = r_count;
  assign bus.busy      = (r_state == READ) || (r_state == CMP) || (r_state == WRITE);
  assign bus.done      = (r_state == DONE);
  assign bus.full      = (r_state == DONE) && r_rej;
endmodule

// File: tb/tb_sorted_insert.sv
// Directed bench for sorted_insert: a sorted-queue reference model predicts the write sequence,
// latency, count and final RAM image of every insert; a few literal values pin that model.
module tb_sorted_insert;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sorted_insert_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sorted_insert #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Synchronous-read single-port RAM, read-before-write.
  logic [DW-1:0] mem [N];
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int  total = 0;
  int  bad   = 0;
  int  model_q[$];
  wr_t exp_wr[$];
  int  obs_addr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every RAM write the DUT issues must be the next one the model predicted.
  always @(negedge clk) begin
    wr_t w;
    if (reset && bus.ram_wren) begin
      obs_addr.push_back(int'(bus.ram_addr));
      if (exp_wr.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        w = exp_wr.pop_front();
        check("wr_addr", 32'(bus.ram_addr), 32'(w.addr));
        check("wr_data", 32'(bus.ram_wdata), 32'(w.data));
      end
    end
  end

  // lit_lat >= 0 adds a hand-computed latency check; hold keeps s high that many extra DONE cycles.
  task automatic do_insert(input int v, input int lit_lat, input int hold);
    int c, k, exp_lat, exp_full, lat;
    c = model_q.size();
    exp_wr.delete();
    obs_addr.delete();
    if (c == N) begin
      exp_full = 1;
      exp_lat  = 1;
    end else begin
      k = 0;
      foreach (model_q[j]) if (model_q[j] > v) k++;
      for (int j = c - 1; j >= c - k; j--) exp_wr.push_back('{j + 1, model_q[j]});
      exp_wr.push_back('{c - k, v});
      // Latency counts rising edges from the one sampling s through the one entering DONE.
      exp_lat  = (k == c) ? 2 * k + 2 : 2 * k + 4;
      exp_full = 0;
      model_q.insert(c - k, v);
    end

    @(negedge clk);
    bus.data_in = DW'(v);
    bus.s       = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    while (!bus.done && lat < 300) begin
      check("busy_mid", 32'(bus.busy), 32'd1);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(exp_lat));
    if (lit_lat >= 0) check("latency_lit", 32'(lat), 32'(lit_lat));
    check("done", 32'(bus.done), 32'd1);
    check("full", 32'(bus.full), 32'(exp_full));
    check("busy_done", 32'(bus.busy), 32'd0);
    check("count", 32'(bus.count), 32'(model_q.size()));
    check("writes_left", 32'(exp_wr.size()), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_done", 32'(bus.done), 32'd1);
      check("hold_busy", 32'(bus.busy), 32'd0);
    end
    bus.s = 1'b0;
    @(negedge clk);
    check("idle_done", 32'(bus.done), 32'd0);
    foreach (model_q[j]) check("mem", 32'(mem[j]), 32'(model_q[j]));
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    bus.s   = 1'b0;
    @(negedge clk);
    bus.clr = 1'b0;
    check("clr_count", 32'(bus.count), 32'd0);
    model_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s       = 1'b0;
    bus.clr     = 1'b0;
    bus.data_in = '0;
    #2;
    check("rst_addr",  32'(bus.ram_addr),  32'd0);
    check("rst_wdata", 32'(bus.ram_wdata), 32'd0);
    check("rst_wren",  32'(bus.ram_wren),  32'd0);
    check("rst_count", 32'(bus.count),     32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    check("rst_full",  32'(bus.full),      32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Empty array.
    do_insert(20, 2, 0);
    check("lit_empty_mem0", 32'(mem[0]), 32'd20);
    check("lit_empty_count", 32'(bus.count), 32'd1);

    // Stop on compare, one shift; s held through DONE must not restart.
    do_clr();
    do_insert(10, -1, 0);
    do_insert(30, -1, 0);
    do_insert(50, -1, 0);
    do_insert(40, 6, 3);
    check("lit40_m0", 32'(mem[0]), 32'd10);
    check("lit40_m1", 32'(mem[1]), 32'd30);
    check("lit40_m2", 32'(mem[2]), 32'd40);
    check("lit40_m3", 32'(mem[3]), 32'd50);

    // Scan reaches index 0 with three shifts.
    do_clr();
    do_insert(10, -1, 0);
    do_insert(30, -1, 0);
    do_insert(50, -1, 0);
    do_insert(5, 8, 0);
    check("lit5_nwr", 32'(obs_addr.size()), 32'd4);
    if (obs_addr.size() == 4) begin
      check("lit5_a0", 32'(obs_addr[0]), 32'd3);
      check("lit5_a1", 32'(obs_addr[1]), 32'd2);
      check("lit5_a2", 32'(obs_addr[2]), 32'd1);
      check("lit5_a3", 32'(obs_addr[3]), 32'd0);
    end
    check("lit5_m0", 32'(mem[0]), 32'd5);
    check("lit5_m3", 32'(mem[3]), 32'd50);

    // Duplicate lands above the existing equal value without shifting.
    do_clr();
    do_insert(10, -1, 0);
    do_insert(30, -1, 0);
    do_insert(30, 4, 0);
    check("litdup_nwr", 32'(obs_addr.size()), 32'd1);
    check("litdup_m2", 32'(mem[2]), 32'd30);

    // Fill to capacity, then a rejected request.
    do_clr();
    for (int t = 0; t < N; t++) do_insert(((t * 13) % N) * 7 + 1, -1, 0);
    do_insert(99, 1, 0);
    check("litfull_count", 32'(bus.count), 32'd32);
    check("litfull_nwr", 32'(obs_addr.size()), 32'd0);
    do_clr();

    // Async reset while in READ.
    do_insert(5, -1, 0);
    @(negedge clk);
    bus.data_in = 8'd3;
    bus.s       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("read_busy", 32'(bus.busy), 32'd1);
    check("read_addr", 32'(bus.ram_addr), 32'd0);
    check("read_wren", 32'(bus.ram_wren), 32'd0);
    reset = 1'b0;
    #1;
    check("arst_addr",  32'(bus.ram_addr),  32'd0);
    check("arst_wdata", 32'(bus.ram_wdata), 32'd0);
    check("arst_wren",  32'(bus.ram_wren),  32'd0);
    check("arst_count", 32'(bus.count),     32'd0);
    check("arst_busy",  32'(bus.busy),      32'd0);
    check("arst_done",  32'(bus.done),      32'd0);
    check("arst_full",  32'(bus.full),      32'd0);
    bus.s = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_q.delete();
    exp_wr.delete();
    do_insert(7, 2, 0);
    check("lit_rst_mem0", 32'(mem[0]), 32'd7);
    check("lit_rst_count", 32'(bus.count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
